dcache_req_queue: RTL

// - In-order request queue between mem_unit and dcache_interface; absorbs bursts (mostly stores) that HPDC cannot take in time.
// - Holds requests until dcache_interface signals ready; this already covers HPDC ready and same-tag stall.
// - Counts requests issued but not yet responded; provides a drained indication for fences/AMOs.

---
 rtl/drac_pkg.sv | 22 ++
 rtl/dcache_req_queue.sv | 68 ++++++
 2 files changed

// File: rtl/drac_pkg.sv
// drac_pkg: shared request/response types and dcache request queue sizing
package drac_pkg;
  localparam int DCACHE_REQ_QUEUE_DEPTH = 4;
  localparam int DCACHE_MAX_INFLIGHT    = 16;
  typedef enum logic [2:0] {MEM_LD, MEM_SD, MEM_AMO, MEM_LR, MEM_SC} mem_op_t;
  typedef struct packed {
    logic        valid;
    logic        kill;
    mem_op_t     mem_op;
    logic [2:0]  mem_size;
    logic [4:0]  rd;
    logic [39:0] addr;
    logic [63:0] data;
  } req_cpu_dcache_t;
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        ordered;
    logic [4:0]  rd;
    logic [63:0] data;
  } resp_dcache_cpu_t;
endpackage

// File: rtl/dcache_req_queue.sv
// dcache_req_queue: in-order request FIFO between mem_unit and dcache_interface with in-flight tracking
module dcache_req_queue
  import drac_pkg::*;
#(
  parameter int DEPTH        = DCACHE_REQ_QUEUE_DEPTH,
  parameter int MAX_INFLIGHT = DCACHE_MAX_INFLIGHT
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  req_cpu_dcache_t          req_i,
  output logic                     req_ready_o,
  output req_cpu_dcache_t          req_o,
  input  resp_dcache_cpu_t         resp_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               inflight_o,
  output logic                     drained_o
);
  localparam int PW = $clog2(DEPTH);
  req_cpu_dcache_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, present;
  logic unused;
  assign unused      = ^{resp_i.rd, resp_i.data};
  assign req_ready_o = count_o != (PW+1)'(DEPTH);
  assign push        = req_i.valid & req_ready_o & ~flush_i;
  assign present     = (count_o != '0) & (inflight_o != 8'(MAX_INFLIGHT)) & ~flush_i;
  assign pop         = present & resp_i.ready;
  assign drained_o   = (count_o == '0) & (inflight_o == '0) & resp_i.ordered;
  always_comb begin
    req_o       = mem[rd_ptr];
    req_o.valid = present;
  end
  // storage is reset so an empty queue never presents X payload
  always_ff @(posedge clk_i, negedge rstn_i)
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= req_i;
    end
  always_ff @(posedge clk_i, negedge rstn_i)
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count_o <= count_o + (PW+1)'(push) - (PW+1)'(pop);
    end
  // flush leaves issued requests counted: their responses still come back
  always_ff @(posedge clk_i, negedge rstn_i)
    if (!rstn_i) inflight_o <= '0;
    else if (pop & ~resp_i.valid) inflight_o <= inflight_o + 8'd1;
    else if (~pop & resp_i.valid & (inflight_o != '0)) inflight_o <= inflight_o - 8'd1;
  a_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push && count_o == (PW+1)'(DEPTH)));
  a_pop_empty: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(pop && count_o == '0));
  a_resp_idle: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(resp_i.valid && inflight_o == '0));
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (req_o.valid && !resp_i.ready) |=> (flush_i || (req_o.valid && $stable(req_o))));
endmodule
